// File: rtl/processador_pkg.sv
// Shared constants and types for the simple processor datapath and control.
package processador_pkg;

  localparam int unsigned N        = 9;
  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned STEP_W   = 2;
  localparam int unsigned OP_W     = 3;
  localparam int unsigned REG_IDX_W = 3;

  // Instruction step encodings
  typedef enum logic [STEP_W-1:0] {
    T0 = 2'b00,
    T1 = 2'b01,
    T2 = 2'b10,
    T3 = 2'b11
  } step_t;

  // Opcodes
  localparam logic [OP_W-1:0] OP_MV  = 3'b000;
  localparam logic [OP_W-1:0] OP_MVI = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD = 3'b010;
  localparam logic [OP_W-1:0] OP_SUB = 3'b011;

  // Instruction field positions
  localparam int unsigned OP_MSB = 8;
  localparam int unsigned OP_LSB = 6;
  localparam int unsigned RX_MSB = 5;
  localparam int unsigned RX_LSB = 3;
  localparam int unsigned RY_MSB = 2;
  localparam int unsigned RY_LSB = 0;

  // Field extraction helpers for the control unit
  function automatic logic [OP_W-1:0] get_opcode(input logic [N-1:0] ir);
    return ir[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [REG_IDX_W-1:0] get_rx(input logic [N-1:0] ir);
    return ir[RX_MSB:RX_LSB];
  endfunction

  function automatic logic [REG_IDX_W-1:0] get_ry(input logic [N-1:0] ir);
    return ir[RY_MSB:RY_LSB];
  endfunction

endpackage

// File: rtl/datapath_processador_regn.sv
// N-bit load-enabled register with synchronous active-high reset.
module regn #(
  parameter int unsigned N = processador_pkg::N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  // Hold unless enabled; reset wins over load
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/datapath_processador.sv
// Processor datapath: R0..R7, A, G, IR, shared bus, add/sub ALU and step counter.
module datapath_processador #(
  parameter int unsigned N = processador_pkg::N
) (
  input  logic                              Clock,
  input  logic                              Resetn,
  input  logic [N-1:0]                      DIN,
  input  logic                              Run,
  input  logic                              Clear,
  input  logic                              Done,
  input  logic                              IRin,
  input  logic [processador_pkg::NUM_REGS-1:0] Rin,
  input  logic [processador_pkg::NUM_REGS-1:0] Rout,
  input  logic                              Ain,
  input  logic                              Gin,
  input  logic                              Gout,
  input  logic                              DINout,
  input  logic                              AddSub,
  output logic [N-1:0]                      Instrucao,
  output logic [1:0]                        Tstep,
  output logic [N-1:0]                      BusWires,
  output logic                              BusErr
);

  import processador_pkg::*;

  logic [N-1:0] r_q [NUM_REGS];
  logic [N-1:0] a_q;
  logic [N-1:0] g_q;
  logic [N-1:0] alu_res;
  step_t        step_q;
  step_t        step_nxt;

  // General-purpose registers, all loading from the shared bus
  for (genvar i = 0; i < int'(NUM_REGS); i++) begin : g_regs
    regn #(.N(N)) u_r (
      .clk (Clock),
      .rst (Resetn),
      .en  (Rin[i]),
      .d   (BusWires),
      .q   (r_q[i])
    );
  end

  regn #(.N(N)) u_a (
    .clk (Clock),
    .rst (Resetn),
    .en  (Ain),
    .d   (BusWires),
    .q   (a_q)
  );

  regn #(.N(N)) u_g (
    .clk (Clock),
    .rst (Resetn),
    .en  (Gin),
    .d   (alu_res),
    .q   (g_q)
  );

  regn #(.N(N)) u_ir (
    .clk (Clock),
    .rst (Resetn),
    .en  (IRin),
    .d   (BusWires),
    .q   (Instrucao)
  );

  // Bus source select: DIN, then G, then lowest-numbered enabled Ri
  always_comb begin
    BusWires = '0;
    if (DINout) begin
      BusWires = DIN;
    end else if (Gout) begin
      BusWires = g_q;
    end else begin
      for (int i = int'(NUM_REGS) - 1; i >= 0; i--) begin
        if (Rout[i]) begin
          BusWires = r_q[i];
        end
      end
    end
  end

  // Flag any cycle with more than one bus driver requested
  assign BusErr = ($countones({DINout, Gout, Rout}) > 1);

  // Add/sub against the pre-edge A; wraps modulo 2^N
  assign alu_res = AddSub ? (a_q - BusWires) : (a_q + BusWires);

  // Step counter state register
  always_ff @(posedge Clock) begin
    if (Resetn) begin
      step_q <= T0;
    end else begin
      step_q <= step_nxt;
    end
  end

  // Step sequencing: Clear/Done return to T0; Run only matters at T0
  always_comb begin
    step_nxt = step_q;
    if (Clear || Done) begin
      step_nxt = T0;
    end else begin
      case (step_q)
        T0:      step_nxt = Run ? T1 : T0;
        T1:      step_nxt = T2;
        T2:      step_nxt = T3;
        T3:      step_nxt = T0;
        default: step_nxt = T0;
      endcase
    end
  end

  assign Tstep = step_q;

endmodule
